// File: rtl/adc_seq_if.sv
// Control and status bundle between the ADC sequencer and its user / analog front end.
interface adc_seq_if #(
   parameter int SAMP_W = 8
);
   logic              start;
   logic              cont;
   logic              abort;
   logic [SAMP_W-1:0] cfg_samp_len;
   logic [4:0]        cfg_nbits;
   logic              comp_out;
   logic              seq_init;
   logic              seq_samp;
   logic              seq_comp;
   logic              seq_update;
   logic              busy;
   logic              done;
   logic [15:0]       result;
   logic [15:0]       conv_count;

   modport master (
      output start, cont, abort, cfg_samp_len, cfg_nbits, comp_out,
      input  seq_init, seq_samp, seq_comp, seq_update, busy, done, result, conv_count
   );

   modport slave (
      input  start, cont, abort, cfg_samp_len, cfg_nbits, comp_out,
      output seq_init, seq_samp, seq_comp, seq_update, busy, done, result, conv_count
   );
endinterface

// File: rtl/adc_sequencer.sv
// SAR ADC phase sequencer: INIT, SAMP, then N COMP/UPDATE pairs, then DONE.
// Define ADC_SEQ_RESULT_EN to build in comparator-decision capture into result.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   S_IDLE   | waiting for start or cont
//   S_INIT   | seq_init high; latch sample length and bit count
//   S_SAMP   | seq_samp high for L cycles
//   S_COMP   | seq_comp high; comparator decision taken at end
//   S_UPDATE | seq_update high; DAC settles to next bit
//   S_DONE   | done pulse, bump conversion counter
module adc_sequencer #(
   parameter int SAMP_W = 8
) (
   input logic     clk,
   input logic     rst,
   adc_seq_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_SAMP,
      S_COMP,
      S_UPDATE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [SAMP_W-1:0] samp_cnt_q, samp_cnt_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [15:0]       conv_count_q, conv_count_d;

   logic seq_init_q, seq_init_d;
   logic seq_samp_q, seq_samp_d;
   logic seq_comp_q, seq_comp_d;
   logic seq_update_q, seq_update_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   logic [SAMP_W-1:0] samp_load;
   logic [3:0]        bit_load;

   // Counters are loaded with (length - 1) and terminate at zero
   always_comb begin
      samp_load = '0;
      bit_load  = 4'd0;
      if (bus.cfg_samp_len != '0) begin
         samp_load = bus.cfg_samp_len - SAMP_W'(1);
      end
      if (bus.cfg_nbits > 5'd16) begin
         bit_load = 4'd15;
      end else if (bus.cfg_nbits != 5'd0) begin
         bit_load = 4'(bus.cfg_nbits - 5'd1);
      end
   end

   always_comb begin
      state_d      = state_q;
      samp_cnt_d   = samp_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      conv_count_d = conv_count_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start || bus.cont) begin
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            samp_cnt_d = samp_load;
            bit_cnt_d  = bit_load;
            state_d    = S_SAMP;
         end
         S_SAMP: begin
            if (samp_cnt_q == '0) begin
               state_d = S_COMP;
            end else begin
               samp_cnt_d = samp_cnt_q - SAMP_W'(1);
            end
         end
         S_COMP: begin
            state_d = S_UPDATE;
         end
         S_UPDATE: begin
            if (bit_cnt_q == 4'd0) begin
               state_d = S_DONE;
            end else begin
               bit_cnt_d = bit_cnt_q - 4'd1;
               state_d   = S_COMP;
            end
         end
         S_DONE: begin
            state_d = bus.cont ? S_INIT : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (bus.abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end

      if (state_d == S_DONE) begin
         conv_count_d = conv_count_q + 16'd1;
      end

      // Outputs are registered copies of the next-state decode
      seq_init_d   = (state_d == S_INIT);
      seq_samp_d   = (state_d == S_SAMP);
      seq_comp_d   = (state_d == S_COMP);
      seq_update_d = (state_d == S_UPDATE);
      busy_d       = (state_d != S_IDLE);
      done_d       = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         samp_cnt_q   <= '0;
         bit_cnt_q    <= 4'd0;
         conv_count_q <= 16'd0;
         seq_init_q   <= 1'b0;
         seq_samp_q   <= 1'b0;
         seq_comp_q   <= 1'b0;
         seq_update_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         samp_cnt_q   <= samp_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         conv_count_q <= conv_count_d;
         seq_init_q   <= seq_init_d;
         seq_samp_q   <= seq_samp_d;
         seq_comp_q   <= seq_comp_d;
         seq_update_q <= seq_update_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign bus.seq_init   = seq_init_q;
   assign bus.seq_samp   = seq_samp_q;
   assign bus.seq_comp   = seq_comp_q;
   assign bus.seq_update = seq_update_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.conv_count = conv_count_q;

`ifdef ADC_SEQ_RESULT_EN
   logic [15:0] shadow_q, shadow_d;
   logic [15:0] result_q, result_d;

   // bit_cnt_q counts N-1 down to 0, which is exactly the MSB-first bit slot
   always_comb begin
      shadow_d = shadow_q;
      result_d = result_q;
      if (state_q == S_INIT) begin
         shadow_d = 16'd0;
      end else if (state_q == S_COMP) begin
         shadow_d[bit_cnt_q] = bus.comp_out;
      end
      if (state_d == S_DONE) begin
         result_d = shadow_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= 16'd0;
         result_q <= 16'd0;
      end else begin
         shadow_q <= shadow_d;
         result_q <= result_d;
      end
   end

   assign bus.result = result_q;
`else
   assign bus.result = 16'd0;
`endif

endmodule

// File: tb/tb_adc_sequencer.sv
// Scoreboard bench for adc_sequencer: cycle-exact phase checks plus done-time result/count checks.
module tb_adc_sequencer;

   logic clk;
   logic rst;

   adc_seq_if #(.SAMP_W(8)) bus ();

   adc_sequencer #(.SAMP_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int          total;
   int          bad;
   logic [31:0] sb[$];
   logic [15:0] exp_count;
   logic [15:0] last_res;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [5:0] obs();
      return {bus.busy, bus.seq_init, bus.seq_samp, bus.seq_comp, bus.seq_update, bus.done};
   endfunction

   // {busy, init, samp, comp, update, done} for cycle p of a conversion
   function automatic logic [5:0] exp_vec(input int p, input int le, input int ne);
      if (p == 0) return 6'b110000;
      if (p <= le) return 6'b101000;
      if (p <= le + 2 * ne) return (((p - 1 - le) % 2) == 0) ? 6'b100100 : 6'b100010;
      return 6'b100001;
   endfunction

   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            check("done_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("result", 32'(bus.result), 32'(e[31:16]));
            check("conv_count", 32'(bus.conv_count), 32'(e[15:0]));
         end
      end
   end

   task automatic run_seq(input int L, input int N, input logic [15:0] pat,
                          input int nconv, input bit use_cont);
      int          le, ne, plen, k;
      logic [15:0] mask, res;
      le   = (L == 0) ? 1 : L;
      ne   = (N == 0) ? 1 : ((N > 16) ? 16 : N);
      plen = le + 2 * ne + 2;
      mask = (ne == 16) ? 16'hFFFF : ((16'd1 << ne) - 16'd1);
`ifdef ADC_SEQ_RESULT_EN
      res = pat & mask;
`else
      res = 16'd0;
`endif
      for (int c = 0; c < nconv; c++) begin
         exp_count = exp_count + 16'd1;
         sb.push_back({res, exp_count});
      end
      last_res = res;
      bus.cfg_samp_len = 8'(L);
      bus.cfg_nbits    = 5'(N);
      if (use_cont) bus.cont = 1'b1;
      else bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 0; c < nconv; c++) begin
         for (int p = 0; p < plen; p++) begin
            check("phase", 32'(obs()), 32'(exp_vec(p, le, ne)));
            bus.comp_out = 1'b0;
            if (exp_vec(p, le, ne) == 6'b100100) begin
               k = (p - 1 - le) / 2;
               bus.comp_out = pat[ne - 1 - k];
            end
            if (p == 1) begin
               bus.cfg_samp_len = 8'($urandom);
               bus.cfg_nbits    = 5'($urandom);
               if (c == nconv - 1) bus.cont = 1'b0;
            end
            if (p == plen - 1) begin
               bus.cfg_samp_len = 8'(L);
               bus.cfg_nbits    = 5'(N);
            end
            if (!use_cont) bus.start = (p == 2);
            @(posedge clk); #1;
         end
      end
      bus.start = 1'b0;
      check("idle_after", 32'(obs()), 32'd0);
      @(posedge clk); #1;
      check("idle_stays", 32'(obs()), 32'd0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      exp_count = 16'd0;
      last_res  = 16'd0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.cont  = 1'b0;
      bus.abort = 1'b0;
      bus.cfg_samp_len = 8'd0;
      bus.cfg_nbits    = 5'd0;
      bus.comp_out     = 1'b0;

      #12;
      check("rst_phase", 32'(obs()), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_count", 32'(bus.conv_count), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run_seq(4, 8, 16'h00B2, 1, 1'b0);
      run_seq(0, 0, 16'h0001, 1, 1'b0);
      run_seq(2, 31, 16'hA5C3, 1, 1'b0);
      run_seq(2, 3, 16'h0005, 3, 1'b1);

      // abort on the third COMP cycle of an L=3, N=8 conversion (cycle index 8)
      bus.cfg_samp_len = 8'd3;
      bus.cfg_nbits    = 5'd8;
      bus.start        = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int p = 0; p <= 8; p++) begin
         check("abort_phase", 32'(obs()), 32'(exp_vec(p, 3, 8)));
         bus.comp_out = 1'b1;
         if (p == 8) bus.abort = 1'b1;
         @(posedge clk); #1;
      end
      bus.abort = 1'b0;
      check("abort_idle", 32'(obs()), 32'd0);
      check("abort_result", 32'(bus.result), 32'(last_res));
      check("abort_count", 32'(bus.conv_count), 32'(exp_count));
      repeat (3) @(posedge clk);
      #1;
      check("abort_still_idle", 32'(obs()), 32'd0);

      // asynchronous reset during SAMP
      bus.cfg_samp_len = 8'd5;
      bus.cfg_nbits    = 5'd2;
      bus.start        = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_samp", 32'(obs()), 32'(exp_vec(1, 5, 2)));
      #2;
      rst = 1'b1;
      #1;
      check("midrst_phase", 32'(obs()), 32'd0);
      check("midrst_result", 32'(bus.result), 32'd0);
      check("midrst_count", 32'(bus.conv_count), 32'd0);
      exp_count = 16'd0;
      last_res  = 16'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // counter wrap
      force dut.conv_count_q = 16'hFFFF;
      @(posedge clk); #1;
      release dut.conv_count_q;
      @(posedge clk); #1;
      check("preset_count", 32'(bus.conv_count), 32'h0000FFFF);
      exp_count = 16'hFFFF;
      run_seq(1, 2, 16'h0002, 1, 1'b0);
      check("wrap_count", 32'(bus.conv_count), 32'd0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_sequencer.md
ADC_SEQUENCER -- requirements
Module: adc_sequencer

Interface
REQ-001 Parameter SAMP_W, default 8: width of the sampling-length configuration input.
REQ-002 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request one conversion; sampled in IDLE only.
REQ-006 cont  input  1  continuous mode; re-arm after each conversion while high.
REQ-007 abort  input  1  synchronous abort of the conversion in progress.
REQ-008 cfg_samp_len  input  SAMP_W  sampling phase length in clk cycles.
REQ-009 cfg_nbits  input  5  comparison cycles per conversion (1..16).
REQ-010 comp_out  input  1  comparator positive output from the adc block.
REQ-011 seq_init, seq_samp, seq_comp, seq_update  output  1 each  phase timing to the adc block.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at conversion completion.
REQ-014 result  output  16  captured comparator decisions, MSB first.
REQ-015 conv_count  output  16  count of completed conversions.

Function
REQ-016 All outputs SHALL come directly from flops, with no combinational path from any input, so they can drive clock gates glitch-free.
REQ-017 States SHALL be IDLE, INIT, SAMP, COMP, UPDATE and DONE.
REQ-018 IDLE SHALL go to INIT on the edge sampling start=1 or cont=1; start asserted in any other state SHALL be ignored.
REQ-019 INIT SHALL last 1 cycle with seq_init=1, then go to SAMP.
REQ-020 SAMP SHALL last L cycles with seq_samp=1, where L=cfg_samp_len and 0 is treated as 1, then go to COMP.
REQ-021 Each bit SHALL take 1 COMP cycle (seq_comp=1) followed by 1 UPDATE cycle (seq_update=1).
REQ-022 After UPDATE, the block SHALL go to COMP while bits remain, else to DONE.
REQ-023 N SHALL be cfg_nbits, with 0 treated as 1 and values above 16 clamped to 16.
REQ-024 cfg_samp_len and cfg_nbits SHALL be latched in INIT and held constant for the rest of the conversion.
REQ-025 DONE SHALL last 1 cycle with done=1, then go to INIT if cont=1, else to IDLE.
REQ-026 Latency: from the edge that samples start, done SHALL be high in cycle 2+L+2N.
REQ-027 At most one seq_* output SHALL be high in any cycle, and all seq_* outputs SHALL be low in IDLE and DONE.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with seq_* low, no done pulse, and result and conv_count unchanged.
REQ-029 abort SHALL have priority over every other transition.
REQ-030 cont deasserted mid-conversion SHALL let the current conversion complete, then return to IDLE.
REQ-031 conv_count SHALL increment on each DONE and wrap from 0xFFFF to 0x0000.

Reset
REQ-032 On rst=1 the block SHALL immediately enter IDLE, asynchronously.
REQ-033 While in reset, all seq_* outputs, busy, done, result and conv_count SHALL be 0.
REQ-034 Reset mid-conversion SHALL discard the partial result.

Configuration
REQ-035 Macro ADC_SEQ_RESULT_EN SHALL compile in result capture.
REQ-036 With ADC_SEQ_RESULT_EN, for bit k = 0..N-1, comp_out SHALL be sampled at the edge ending that bit's COMP cycle into a shadow register at bit position N-1-k.
REQ-037 With ADC_SEQ_RESULT_EN, bits N..15 of the shadow register SHALL be 0.
REQ-038 With ADC_SEQ_RESULT_EN, the shadow register SHALL be cleared in INIT and copied to result on entry to DONE; result SHALL hold until the next DONE.
REQ-039 Without ADC_SEQ_RESULT_EN, result SHALL be constant 0, comp_out SHALL be unused, and no capture flops SHALL exist.

Verification
REQ-040 Single conversion: cfg_samp_len=4, cfg_nbits=8, start pulse -> seq_init in cycle 1, seq_samp in cycles 2-5, alternating comp/update in cycles 6-21, done in cycle 22, conv_count=1.
REQ-041 Result capture (ADC_SEQ_RESULT_EN): comp_out pattern 1,0,1,1,0,0,1,0 across the COMP cycles -> result=0x00B2 at done; without the macro -> result=0x0000.
REQ-042 Clamping: cfg_nbits=0 -> exactly 1 COMP/UPDATE pair; cfg_nbits=31 -> 16 pairs; cfg_samp_len=0 -> 1 SAMP cycle.
REQ-043 Continuous mode: cont=1 for 3 conversions, then cont=0 during the third -> 3 done pulses, back-to-back DONE->INIT, then IDLE with busy=0.
REQ-044 Abort and reset: abort in the 3rd COMP cycle -> IDLE next cycle, no done, result unchanged; rst mid-SAMP -> all outputs 0 immediately.
REQ-045 Wrap: preset conv_count to 0xFFFF via 65535 conversions (or force) -> next done gives 0x0000; start while busy -> ignored, no extra conversion.
